// File: rtl/core_seq_pkg.sv
// Shared types for the multi-cycle RV32I sequencer: FSM states, opcodes,
// error codes and instruction classes.
package core_seq_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR
  } cls_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_ILLEGAL  = 2'd1,
    ERR_MISALIGN = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_e;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/core_seq_decode.sv
// Combinational opcode classifier: maps ir[6:0] to an instruction class and
// flags opcodes outside the supported RV32I set.
module core_seq_decode
  import core_seq_pkg::*;
(
  input  logic [6:0] opcode,
  output cls_e       cls,
  output logic       legal
);

  always_comb begin
    cls   = CLS_ALU;
    legal = 1'b1;
    case (opcode)
      OP_OP, OP_IMM, OP_LUI, OP_AUIPC: cls = CLS_ALU;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      OP_BRANCH: cls = CLS_BRANCH;
      OP_JAL:    cls = CLS_JAL;
      OP_JALR:   cls = CLS_JALR;
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer for the non-pipelined RV32I core (PC, IR, FSM).
// Optional CORE_SEQ_TIMEOUT_EN halts on a memory ack that never arrives.
module core_seq_ctrl
  import core_seq_pkg::*;
#(
  parameter int              PC_W         = 32,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              MEM_WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     ir,
  output logic [PC_W-1:0] pc,
  input  logic [31:0]     imm,
  input  logic [PC_W-1:0] alu_res,
  input  logic            alu_zero,
  input  logic            alu_lt,
  output logic [4:0]      br_addr,
  input  logic            br_taken,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            rf_we,
  output logic            retire,
  output logic [31:0]     instret,
  output logic            halted,
  output logic [1:0]      err_code
);

  // Handshake: a req stays high until the cycle its ack is seen; that cycle
  // completes the transfer. An ack while the matching req is low is ignored.
  state_e          state_q, state_d;
  err_e            err_q, err_d;
  cls_e            cls;
  logic            legal;
  logic            active_q;
  logic            commit, pc_load, timeout;
  logic [PC_W-1:0] seq_pc, imm_pc, tgt;
  logic            unused_alu_lsb;

  core_seq_decode u_decode (
    .opcode (ir[6:0]),
    .cls    (cls),
    .legal  (legal)
  );

  assign seq_pc         = pc + PC_W'(4);
  assign imm_pc         = pc + imm[PC_W-1:0];
  assign imem_addr      = pc;
  assign br_addr        = {alu_zero, alu_lt, ir[14:12]};
  assign halted         = (state_q == S_HALT);
  assign err_code       = err_q;
  assign unused_alu_lsb = alu_res[0];

`ifdef CORE_SEQ_TIMEOUT_EN
  logic [31:0] wait_q;
  logic        waiting;

  assign waiting = ((state_q == S_FETCH) && active_q && !imem_ack) ||
                   ((state_q == S_MEM) && !dmem_ack);
  assign timeout = waiting && (wait_q == 32'(MEM_WAIT_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= '0;
    else        wait_q <= waiting ? wait_q + 32'd1 : '0;
  end
`else
  logic [31:0] unused_wait_max;
  assign unused_wait_max = 32'(MEM_WAIT_MAX);
  assign timeout         = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    tgt      = seq_pc;
    commit   = 1'b0;
    pc_load  = 1'b0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    retire   = 1'b0;
    case (state_q)
      S_FETCH: begin
        // active_q keeps the first request off until the first edge after reset
        imem_req = active_q;
        if (imem_req && imem_ack) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_HALT;
          err_d   = ERR_ILLEGAL;
        end
      end
      S_EXEC: begin
        if (cls == CLS_BRANCH) begin
          tgt    = br_taken ? imm_pc : seq_pc;
          commit = 1'b1;
        end else if (cls == CLS_LOAD || cls == CLS_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == CLS_STORE);
        if (dmem_ack) begin
          if (cls == CLS_STORE) commit  = 1'b1;
          else                  state_d = S_WB;
        end else if (timeout) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        commit = 1'b1;
        if (cls == CLS_JAL)       tgt = imm_pc;
        else if (cls == CLS_JALR) tgt = {alu_res[PC_W-1:1], 1'b0};
      end
      S_HALT: ;
      default: state_d = S_HALT;
    endcase
    // A misaligned target traps the instruction: no PC load, write or retire.
    if (commit) begin
      if (tgt[1:0] != 2'b00) begin
        state_d = S_HALT;
        err_d   = ERR_MISALIGN;
        rf_we   = 1'b0;
      end else begin
        retire  = 1'b1;
        pc_load = 1'b1;
        state_d = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      err_q    <= ERR_NONE;
      active_q <= 1'b0;
      pc       <= RESET_PC;
      ir       <= '0;
      instret  <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      active_q <= 1'b1;
      if (imem_req && imem_ack) ir <= imem_rdata;
      if (pc_load) pc <= tgt;
      if (retire) instret <= instret + 32'd1;
    end
  end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: a per-instruction timeline model feeds an
// expected queue that one compare process checks every cycle.
module tb_core_seq_ctrl;

  localparam int          PC_W         = 32;
  localparam logic [31:0] RESET_PC     = 32'h0;
  localparam int          MEM_WAIT_MAX = 15;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_JAL = 4, K_JALR = 5, K_ILL = 6;

  logic        clk, rst_n;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic        rf_we, retire, halted, alu_zero, alu_lt, br_taken;
  logic [31:0] imem_addr, imem_rdata, ir, pc, imm, alu_res, instret;
  logic [4:0]  br_addr;
  logic [1:0]  err_code;

  core_seq_ctrl #(
    .PC_W(PC_W), .RESET_PC(RESET_PC), .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .pc(pc), .imm(imm), .alu_res(alu_res), .alu_zero(alu_zero), .alu_lt(alu_lt),
    .br_addr(br_addr), .br_taken(br_taken),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .retire(retire), .instret(instret), .halted(halted), .err_code(err_code)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // ctl = {imem_req, dmem_req, dmem_we, rf_we, retire, halted}
  typedef struct packed {
    logic [5:0]  ctl;
    logic [31:0] pc;
    logic [31:0] instret;
    logic [1:0]  err;
    logic        chk_br;
    logic [4:0]  br;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur_e;
  int          checks, errors;
  int          dmem_cnt, rfwe_cnt;
  logic [31:0] m_pc, m_instret;
  logic [1:0]  m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur_e = exp_q.pop_front();
      check("ctl", {26'd0, imem_req, dmem_req, dmem_we, rf_we, retire, halted}, {26'd0, cur_e.ctl});
      check("pc", pc, cur_e.pc);
      check("imem_addr", imem_addr, cur_e.pc);
      check("instret", instret, cur_e.instret);
      check("err_code", {30'd0, err_code}, {30'd0, cur_e.err});
      if (cur_e.chk_br) check("br_addr", {27'd0, br_addr}, {27'd0, cur_e.br});
    end
  end

  always @(negedge clk) begin
    if (dmem_req) dmem_cnt++;
    if (rf_we) rfwe_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] ctl, input logic chk_br, input logic [4:0] br);
    exp_t e;
    e.ctl = ctl; e.pc = m_pc; e.instret = m_instret; e.err = m_err;
    e.chk_br = chk_br; e.br = br;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ack = 0; imem_rdata = 0; imm = 0; alu_res = 0; alu_zero = 0; alu_lt = 0;
    br_taken = 0; dmem_ack = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, RESET_PC);
    check("rst_ir", ir, 32'h0);
    check("rst_instret", instret, 32'h0);
    check("rst_err", {30'd0, err_code}, 32'h0);
    check("rst_ctl", {26'd0, imem_req, dmem_req, dmem_we, rf_we, retire, halted}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("no_req_before_first_edge", {31'd0, imem_req}, 32'h0);
    step();
    m_pc = RESET_PC; m_instret = 0; m_err = 0;
  endtask

  // Runs one instruction from its first fetch cycle; ncyc = cycles until retire/halt.
  task automatic run_instr(input logic [31:0] instr, input logic [31:0] imm_v,
                           input logic [31:0] alu_v, input logic z, input logic l,
                           input logic t, input int iwait, input int dwait, output int ncyc);
    int          kind;
    logic [31:0] tgt;
    logic        mis;
    case (instr[6:0])
      7'h33, 7'h13, 7'h37, 7'h17: kind = K_ALU;
      7'h03:   kind = K_LOAD;
      7'h23:   kind = K_STORE;
      7'h63:   kind = K_BR;
      7'h6f:   kind = K_JAL;
      7'h67:   kind = K_JALR;
      default: kind = K_ILL;
    endcase
    if (kind == K_BR)        tgt = t ? m_pc + imm_v : m_pc + 32'd4;
    else if (kind == K_JAL)  tgt = m_pc + imm_v;
    else if (kind == K_JALR) tgt = {alu_v[31:1], 1'b0};
    else                     tgt = m_pc + 32'd4;
    mis  = (tgt[1:0] != 2'b00);
    ncyc = 0;
    imm = imm_v; alu_res = alu_v; alu_zero = z; alu_lt = l; br_taken = t;
    for (int i = 0; i <= iwait; i++) begin
      imem_ack   = (i == iwait);
      imem_rdata = (i == iwait) ? instr : 32'h0;
      push(6'b100000, 1'b0, 5'd0);
      step(); ncyc++;
    end
    imem_ack = 0; imem_rdata = 0;
    dmem_ack = 1'b1;  // stray ack while dmem_req is low
    push(6'b000000, 1'b0, 5'd0);
    step(); ncyc++;
    dmem_ack = 1'b0;
    if (kind == K_ILL) begin
      m_err = 2'd1;
      return;
    end
    if (kind == K_BR) begin
      push(mis ? 6'b000000 : 6'b000010, 1'b1, {z, l, instr[14:12]});
      if (mis) m_err = 2'd2;
      else begin m_pc = tgt; m_instret++; end
      step(); ncyc++;
      return;
    end
    push(6'b000000, 1'b0, 5'd0);
    step(); ncyc++;
    if (kind == K_LOAD || kind == K_STORE) begin
      for (int i = 0; i <= dwait; i++) begin
        dmem_ack = (i == dwait);
        if (kind == K_STORE) begin
          push((i == dwait) ? 6'b011010 : 6'b011000, 1'b0, 5'd0);
          if (i == dwait) begin m_pc = tgt; m_instret++; end
        end else begin
          push(6'b010000, 1'b0, 5'd0);
        end
        step(); ncyc++;
      end
      dmem_ack = 1'b0;
      if (kind == K_STORE) return;
    end
    push(mis ? 6'b000000 : 6'b000110, 1'b0, 5'd0);
    if (mis) m_err = 2'd2;
    else begin m_pc = tgt; m_instret++; end
    step(); ncyc++;
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      push(6'b000001, 1'b0, 5'd0);
      step();
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    checks = 0; errors = 0; dmem_cnt = 0; rfwe_cnt = 0;
    m_pc = RESET_PC; m_instret = 0; m_err = 0;
    do_reset();

    run_instr(32'h00100093, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 0, 0, n);  // addi
    check("addi_cycles", n, 32'd4);
    check("addi_pc", pc, 32'h4);
    check("addi_instret", instret, 32'd1);
    check("addi_ir", ir, 32'h00100093);

    run_instr(32'h000120B7, 32'h12000, 32'h12000, 1'b0, 1'b0, 1'b0, 2, 0, n);  // lui, 2 waits
    check("lui_cycles", n, 32'd6);

    rfwe_cnt = 0;
    run_instr(32'h00000063, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 0, 0, n);  // beq taken at 0x8
    check("beq_cycles", n, 32'd3);
    check("beq_pc", pc, 32'h18);
    check("beq_no_rf_we", rfwe_cnt, 32'd0);

    run_instr(32'h00001063, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0, 0, 0, n);  // bne not taken
    check("bne_pc", pc, 32'h1c);

    dmem_cnt = 0; rfwe_cnt = 0;
    run_instr(32'h00002083, 32'h0, 32'h100, 1'b0, 1'b0, 1'b0, 0, 3, n);  // lw, 3 waits
    check("lw_cycles", n, 32'd8);
    check("lw_dmem_req_cycles", dmem_cnt, 32'd4);
    check("lw_rf_we_pulses", rfwe_cnt, 32'd1);

    run_instr(32'h00202023, 32'h0, 32'h100, 1'b0, 1'b0, 1'b0, 0, 1, n);  // sw, 1 wait
    check("sw_cycles", n, 32'd5);
    check("sw_pc", pc, 32'h24);

    run_instr(32'h0100006F, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0, n);  // jal
    check("jal_pc", pc, 32'h124);
    run_instr(32'h000080E7, 32'h0, 32'h201, 1'b0, 1'b0, 1'b0, 1, 0, n);  // jalr, lsb cleared
    check("jalr_pc", pc, 32'h200);
    run_instr(32'h00000097, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0, n);  // auipc
    run_instr(32'h002081B3, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0, n);  // add
    check("seq_pc", pc, 32'h208);
    check("seq_instret", instret, 32'd10);

    run_instr(32'h0000007F, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0, n);  // illegal
    halt_cycles(5);
    check("ill_err", {30'd0, err_code}, 32'd1);
    check("ill_pc", pc, 32'h208);

    do_reset();
    run_instr(32'h000080E7, 32'h0, 32'h102, 1'b0, 1'b0, 1'b0, 0, 0, n);  // misaligned jalr
    halt_cycles(4);
    check("jalr_mis_err", {30'd0, err_code}, 32'd2);
    check("jalr_mis_pc", pc, 32'h0);
    check("jalr_mis_instret", instret, 32'd0);

    do_reset();
    run_instr(32'h00000063, 32'h6, 32'h0, 1'b1, 1'b0, 1'b1, 0, 0, n);  // misaligned branch
    halt_cycles(3);
    check("br_mis_err", {30'd0, err_code}, 32'd2);

    // Reset during a MEM wait.
    do_reset();
    run_instr(32'h00100093, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 0, 0, n);
    imem_ack = 1'b1; imem_rdata = 32'h00002083;
    step();
    imem_ack = 1'b0; imem_rdata = 32'h0;
    step(); step(); step();
    check("abort_dmem_req_before", {31'd0, dmem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_dmem_req_after", {31'd0, dmem_req}, 32'd0);
    check("abort_pc", pc, RESET_PC);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("abort_refetch", {31'd0, imem_req}, 32'd1);
    m_pc = RESET_PC; m_instret = 0; m_err = 0;
    run_instr(32'h00100093, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 0, 0, n);
    check("abort_then_addi_pc", pc, 32'h4);

    // Fetch ack never arrives.
    do_reset();
    imem_ack = 1'b0;
`ifdef CORE_SEQ_TIMEOUT_EN
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!imem_req) break;
      n++;
      step();
    end
    check("timeout_req_cycles", n, MEM_WAIT_MAX);
    check("timeout_halted", {31'd0, halted}, 32'd1);
    check("timeout_err", {30'd0, err_code}, 32'd3);
`else
    repeat (99) step();
    check("no_timeout_req_at_100", {31'd0, imem_req}, 32'd1);
    check("no_timeout_halted", {31'd0, halted}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_seq_ctrl.md
# core_seq_ctrl

Multi-cycle sequencer for the non-pipelined RV32I core. It owns the PC and instruction register, and steps each instruction through fetch, decode, execute, memory and writeback with req/ack handshakes to instruction and data memory. It drives the 5-bit address of the branch decision table, uses the returned taken bit to choose the next PC, and halts on illegal or misaligned instructions.

## Interface
- `PC_W`, 32, PC/address width
- `RESET_PC`, 0, PC value after reset
- `MEM_WAIT_MAX`, 15, maximum ack wait cycles (used only with timeout feature)

- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `imem_req` out 1: instruction fetch request
- `imem_addr` out PC_W: equals `pc`
- `imem_ack` in 1: fetch data valid
- `imem_rdata` in 32: fetched instruction
- `ir` out 32: latched instruction
- `pc` out PC_W: current PC
- `imm` in 32: immediate from the immediate generator, decoded from `ir`
- `alu_res` in PC_W: ALU result, used as the jalr target
- `alu_zero` in 1: ALU zero flag
- `alu_lt` in 1: ALU less-than flag
- `br_addr` out 5: branch table address
- `br_taken` in 1: branch table output (combinational)
- `dmem_req` out 1: data memory request
- `dmem_we` out 1: store qualifier
- `dmem_ack` in 1: data access done
- `rf_we` out 1: register file write enable
- `retire` out 1: one-cycle pulse when an instruction completes
- `instret` out 32: retired-instruction count, wraps
- `halted` out 1: sticky halt
- `err_code` out 2: 0 none, 1 illegal opcode, 2 misaligned target, 3 memory timeout

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- **FETCH**
  - Holds `imem_req` high until `imem_ack`.
  - On the ack cycle, latches `ir <= imem_rdata` and goes to DECODE.
- **DECODE**
  - Classifies `ir[6:0]`.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Any other opcode goes to HALT with `err_code`=1.
- **EXEC**
  - Branch:
    - `br_addr = {alu_zero, alu_lt, ir[14:12]}`. `br_addr` is driven in every state; it is meaningful in EXEC.
    - Next PC = `pc+imm` if `br_taken`, else `pc+4`.
    - Then FETCH, with a retire.
  - Load/store: go to MEM.
  - All other instructions: go to WB.
- **MEM**
  - Holds `dmem_req` high until `dmem_ack`.
  - `dmem_we` = 1 for stores.
  - Load goes to WB. Store goes to FETCH with next PC `pc+4`, with a retire.
- **WB**
  - `rf_we` high for exactly this one cycle.
  - Next PC is `pc+imm` for jal, `{alu_res[PC_W-1:1],1'b0}` for jalr, and `pc+4` otherwise.
  - Then FETCH, with a retire.
- **Target alignment:** any computed next PC with bits[1:0]≠0 is not loaded. The block goes to HALT with `err_code`=2 and no retire; `pc` keeps the faulting instruction's address.
- **HALT:** all requests and `rf_we` are 0. `halted` is 1. The state is left only by reset.
- **PC arithmetic** is modulo 2^PC_W. No overflow detection.
- **Acks:** an ack arriving while the matching req is low is ignored.

## Timing
- **Reset values:** state FETCH, `pc`=RESET_PC, `ir`=0, `instret`=0, `err_code`=0. All other outputs are 0.
- **Reset assertion** mid-operation aborts any pending request in the same cycle, because reset is asynchronous.
- **Cycles per instruction**, with zero-wait acks (ack in the first req cycle):
  - branch: 3
  - ALU/lui/auipc/jal/jalr: 4
  - store: 4
  - load: 5
- Each wait cycle adds one cycle.
- `retire` pulses in the same cycle that `pc` updates. `instret` increments on that edge.
- `imem_req` rises in the first cycle after reset release.

## Configuration
- **`CORE_SEQ_TIMEOUT_EN` defined:** a wait counter runs in FETCH and MEM.
  - It clears on state entry.
  - If `MEM_WAIT_MAX` cycles pass without an ack, the block goes to HALT with `err_code`=3.
  - An ack arriving on the MEM_WAIT_MAX-th cycle is accepted.
- **Undefined:** the block waits indefinitely, and `err_code` 3 is never produced.

## Structure
- **Package `core_seq_pkg`:**
  - state enum
  - opcode localparams
  - `err_code` encoding
  - instruction-class enum
- **Sub-module `core_seq_decode`:** combinational opcode to class/legal decoder, instantiated once.

## Test plan
- **Reset, then addi at 0x0 with zero-wait acks:** `imem_req` in cycle 1; `rf_we` in cycle 4; `retire` in cycle 4; `pc`=0x4; `instret`=1.
- **beq taken:** `alu_zero`=1, `alu_lt`=0, funct3 000 → `br_addr`=0b10000; with `br_taken`=1 and `imm`=0x10 at pc 0x8 → `pc`=0x18 after 3 cycles; `rf_we` never asserted.
- **Load with `dmem_ack` delayed 3 cycles:** `dmem_req` high for 4 cycles; instruction takes 8 cycles; single `rf_we` pulse.
- **Illegal opcode 0x0000007F, or jalr with `alu_res`=0x102:** HALT; `err_code` 1 or 2 respectively; `pc` unchanged; no further `imem_req`.
- **Timeout (macro defined, `MEM_WAIT_MAX`=15, `imem_ack` held low):** HALT after 15 cycles with `err_code`=3. With the macro undefined, `imem_req` is still high at cycle 100.
- **`rst_n` pulsed low during a MEM wait:** `dmem_req` drops immediately; after release `pc`=RESET_PC and FETCH restarts.
